// File: rtl/mdu_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation codes and FSM state encoding.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mdu_state_t;

    function automatic logic mdu_is_signed(input mdu_op_t op_i);
        return (op_i == MDU_MULT) || (op_i == MDU_DIV);
    endfunction

    function automatic logic mdu_is_div(input mdu_op_t op_i);
        return (op_i == MDU_DIV) || (op_i == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign correction.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Negate when requested, otherwise pass through
    always_comb begin
        if (neg) begin
            dout = ~din + ONE;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle HI/LO multiply/divide unit (shift-add multiply, restoring divide, one bit per cycle).
// Divider is present only when MDU_DIV_EN is defined; otherwise DIV/DIVU complete with `illegal`.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};

    mdu_state_t         state_r, state_nxt_s;
    logic [CW-1:0]      cnt_r;
    logic               sa_r, sb_r;
    logic [WIDTH-1:0]   mcand_r, mplier_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               busy_r, done_r, illegal_r;
    logic               illegal_nxt_s, div_zero_nxt_s;

    logic               signed_op_s, op_is_div_s, sa_s, sb_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   res_hi_s, res_lo_s;

    assign signed_op_s = mdu_is_signed(mdu_op_t'(op));
    assign op_is_div_s = mdu_is_div(mdu_op_t'(op));
    assign sa_s        = a[WIDTH-1] & signed_op_s;
    assign sb_s        = b[WIDTH-1] & signed_op_s;

    mdu_sign_fix #(.W(WIDTH)) u_mag_a (.din(a), .neg(sa_s), .dout(mag_a_s));
    mdu_sign_fix #(.W(WIDTH)) u_mag_b (.din(b), .neg(sb_s), .dout(mag_b_s));

    // Upper accumulator half plus the multiplicand gated by the current multiplier bit
    assign mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r & {WIDTH{mplier_r[0]}}};

    mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (.din(acc_r), .neg(sa_r ^ sb_r), .dout(prod_s));

`ifdef MDU_DIV_EN
    logic             is_div_r;
    logic             div_zero_r;
    logic [WIDTH-1:0] rem_r, quo_r;
    logic [WIDTH:0]   rem_shift_s, trial_s;
    logic [WIDTH-1:0] quo_fix_s, rem_fix_s;

    assign rem_shift_s = {rem_r, quo_r[WIDTH-1]};
    assign trial_s     = rem_shift_s - {1'b0, mcand_r};

    mdu_sign_fix #(.W(WIDTH)) u_fix_quo (.din(quo_r), .neg(sa_r ^ sb_r), .dout(quo_fix_s));
    mdu_sign_fix #(.W(WIDTH)) u_fix_rem (.din(rem_r), .neg(sa_r),        .dout(rem_fix_s));

    assign div_zero = div_zero_r;
`else
    assign div_zero = 1'b0;
`endif

    // Select the sign-corrected result written into HI/LO
    always_comb begin
        res_hi_s = prod_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_s[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (is_div_r) begin
            res_hi_s = rem_fix_s;
            res_lo_s = quo_fix_s;
        end else begin
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end
`endif
    end

    // Next-state and completion-flag decode
    always_comb begin
        state_nxt_s    = state_r;
        illegal_nxt_s  = 1'b0;
        div_zero_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!start) begin
                    state_nxt_s = ST_IDLE;
                end else if (op_is_div_s) begin
`ifdef MDU_DIV_EN
                    if (b == ZERO_W) begin
                        state_nxt_s    = ST_DONE;
                        div_zero_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
`else
                    state_nxt_s   = ST_DONE;
                    illegal_nxt_s = 1'b1;
`endif
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FIX:  state_nxt_s = ST_DONE;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and registered status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
`ifdef MDU_DIV_EN
            div_zero_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_nxt_s;
            busy_r    <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_FIX);
            done_r    <= (state_nxt_s == ST_DONE);
            illegal_r <= illegal_nxt_s;
`ifdef MDU_DIV_EN
            div_zero_r <= div_zero_nxt_s;
`endif
        end
    end

    // Operand capture, iteration datapath and HI/LO write-back
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r    <= CNT_ZERO;
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            mcand_r  <= ZERO_W;
            mplier_r <= ZERO_W;
            acc_r    <= {(2*WIDTH){1'b0}};
            hi_r     <= ZERO_W;
            lo_r     <= ZERO_W;
`ifdef MDU_DIV_EN
            is_div_r <= 1'b0;
            rem_r    <= ZERO_W;
            quo_r    <= ZERO_W;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cnt_r    <= CNT_ZERO;
                        sa_r     <= sa_s;
                        sb_r     <= sb_s;
                        acc_r    <= {(2*WIDTH){1'b0}};
                        mplier_r <= mag_b_s;
`ifdef MDU_DIV_EN
                        is_div_r <= op_is_div_s;
                        rem_r    <= ZERO_W;
                        quo_r    <= mag_a_s;
                        // The divisor shares the multiplicand register
                        mcand_r  <= op_is_div_s ? mag_b_s : mag_a_s;
`else
                        mcand_r  <= mag_a_s;
`endif
                    end
                end
                ST_RUN: begin
                    cnt_r <= cnt_r + CNT_ONE;
`ifdef MDU_DIV_EN
                    if (is_div_r) begin
                        if (!trial_s[WIDTH]) begin
                            rem_r <= trial_s[WIDTH-1:0];
                            quo_r <= {quo_r[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_r <= rem_shift_s[WIDTH-1:0];
                            quo_r <= {quo_r[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_r    <= {mul_sum_s, acc_r[WIDTH-1:1]};
                        mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    end
`else
                    acc_r    <= {mul_sum_s, acc_r[WIDTH-1:1]};
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
`endif
                end
                ST_FIX: begin
                    hi_r <= res_hi_s;
                    lo_r <= res_lo_s;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign illegal = illegal_r;
    assign hi      = hi_r;
    assign lo      = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH=32); follows the MDU_DIV_EN build option.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int WIDTH = 32;
    localparam int MUL_LAT = WIDTH + 1;

    logic             clock = 1'b0;
    logic             reset, start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a, b, hi, lo;
    logic             busy, done, div_zero, illegal;

    int n_checks = 0;
    int n_fails  = 0;
    int lat, busy_cnt, done_cnt;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .illegal(illegal),
        .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one op, scramble operands while it runs, return done latency and busy cycles
    task automatic issue_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                            output int lat_o, output int busy_o);
        @(negedge clock);
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        @(posedge clock); #1;
        start = 1'b0; op = ~op_i; a = 32'hDEAD_BEEF; b = 32'h0000_0000;
        lat_o = 0; busy_o = 0;
        while (!done && lat_o < 100) begin
            if (busy) busy_o++;
            @(posedge clock); #1;
            lat_o++;
        end
        check_value("done_seen", 64'(done), 64'd1);
    endtask

    task automatic check_result(input string tag, input int exp_lat, input logic [31:0] exp_hi,
                                input logic [31:0] exp_lo, input logic exp_dz, input logic exp_il);
        check_value({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_value({tag, "_busy"}, 64'(busy_cnt), 64'(exp_lat));
        check_value({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check_value({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check_value({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
        check_value({tag, "_il"}, 64'(illegal), 64'(exp_il));
        @(posedge clock); #1;
        check_value({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        check_value("rst_hi", 64'(hi), 64'd0);
        check_value("rst_lo", 64'(lo), 64'd0);
        check_value("rst_busy", 64'(busy), 64'd0);
        check_value("rst_done", 64'(done), 64'd0);
        check_value("rst_dz", 64'(div_zero), 64'd0);
        check_value("rst_il", 64'(illegal), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        issue_op(MDU_MULT, 32'hFFFF_FFFD, 32'h0000_0005, lat, busy_cnt);
        check_result("mult_m3x5", MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0);
        issue_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busy_cnt);
        check_result("multu_max", MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        issue_op(MDU_MULT, 32'h8000_0000, 32'h8000_0000, lat, busy_cnt);
        check_result("mult_minsq", MUL_LAT, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
        issue_op(MDU_MULT, 32'h0000_0007, 32'hFFFF_FFFF, lat, busy_cnt);
        check_result("mult_7xm1", MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0, 1'b0);

`ifdef MDU_DIV_EN
        issue_op(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, lat, busy_cnt);
        check_result("div_m7d2", MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        issue_op(MDU_DIVU, 32'd100, 32'd7, lat, busy_cnt);
        check_result("divu_100d7", MUL_LAT, 32'h0000_0002, 32'h0000_000E, 1'b0, 1'b0);
        issue_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_cnt);
        check_result("div_min_m1", MUL_LAT, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
        issue_op(MDU_DIV, 32'h0000_0007, 32'hFFFF_FFFE, lat, busy_cnt);
        check_result("div_7dm2", MUL_LAT, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0);
        issue_op(MDU_DIVU, 32'd59, 32'd6, lat, busy_cnt);
        check_result("divu_59d6", MUL_LAT, 32'h0000_0005, 32'h0000_0009, 1'b0, 1'b0);
        issue_op(MDU_DIVU, 32'd100, 32'd0, lat, busy_cnt);
        check_result("divu_zero", 0, 32'h0000_0005, 32'h0000_0009, 1'b1, 1'b0);
        check_value("divu_zero_flag_clr", 64'(div_zero), 64'd0);
`else
        issue_op(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, lat, busy_cnt);
        check_result("div_illegal", 0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0, 1'b1);
        issue_op(MDU_DIVU, 32'd100, 32'd0, lat, busy_cnt);
        check_result("divu_illegal", 0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0, 1'b1);
        check_value("illegal_flag_clr", 64'(illegal), 64'd0);
`endif

        // Second start during RUN must be dropped
        @(negedge clock);
        start = 1'b1; op = MDU_MULT; a = 32'd3; b = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        start = 1'b1; op = MDU_MULT; a = 32'd2; b = 32'd2;
        @(negedge clock);
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clock); #1;
            if (done) done_cnt++;
        end
        check_value("ignore_done_cnt", 64'(done_cnt), 64'd1);
        check_value("ignore_lo", 64'(lo), 64'd9);
        check_value("ignore_hi", 64'(hi), 64'd0);

        // Reset during RUN iteration 10 aborts without a done
        @(negedge clock);
        start = 1'b1; op = MDU_MULT; a = 32'd3; b = 32'd5;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check_value("abort_busy", 64'(busy), 64'd0);
        check_value("abort_done", 64'(done), 64'd0);
        check_value("abort_hi", 64'(hi), 64'd0);
        check_value("abort_lo", 64'(lo), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (done) done_cnt++;
        end
        check_value("abort_no_done", 64'(done_cnt), 64'd0);
        issue_op(MDU_MULT, 32'd6, 32'd7, lat, busy_cnt);
        check_result("mult_6x7", MUL_LAT, 32'h0000_0000, 32'h0000_002A, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
